list_walker: RTL and testbench
==============================

LIST_WALKER -- requirements
Module: list_walker

Interface
REQ-001 SHALL have parameter WordSize, default 32, meaning the data word width in bits (must be at least AddrWidth).
REQ-002 SHALL have parameter WordsNumber, default 8, meaning the memory depth in words (at least 2).
REQ-003 SHALL have derived parameter AddrWidth = clog2(WordsNumber) and CountWidth = clog2(WordsNumber+1).
REQ-004 Clock  input  1  single clock; all state changes on rising edge.
REQ-005 Reset  input  1  asynchronous, active-low reset.
REQ-006 Write  input  1  load-phase write enable.
REQ-007 WriteAddress  input  AddrWidth  load-phase word address.
REQ-008 WriteData  input  WordSize  load-phase word.
REQ-009 Start  input  1  begin a walk.
REQ-010 StartAddress  input  AddrWidth  first node of the walk.
REQ-011 Busy  output  1  walk in progress.
REQ-012 Valid  output  1  Address/Data show a visited node this cycle.
REQ-013 Address  output  AddrWidth  current node address.
REQ-014 Data  output  WordSize  memory word at Address (combinational read).
REQ-015 Steps  output  CountWidth  nodes visited in the current or last walk.
REQ-016 Done  output  1  one-cycle pulse at walk end.
REQ-017 Reason  output  2  end cause: 0 End, 1 RangeError, 2 Loop; held until next Start.

Function
REQ-018 SHALL implement states IDLE, WALK, DONE.
REQ-019 IDLE: Write=1 writes WriteData to WriteAddress at the rising edge; Start=1 with Write=0 loads Address<=StartAddress, Steps<=0, moves to WALK.
REQ-020 IDLE with Write=1 and Start=1 in the same cycle: write SHALL occur, Start SHALL be ignored.
REQ-021 WALK: Valid=1, Busy=1; each cycle one node is visited, and Steps increments by 1 at the edge.
REQ-022 WALK termination, checked on Data in priority order: Data all-ones -> Reason End; Data >= WordsNumber -> RangeError; Steps+1 == WordsNumber -> Loop.
REQ-023 On termination SHALL go to DONE; otherwise Address <= Data[AddrWidth-1:0].
REQ-024 Latency: first node is visible in the cycle after Start is sampled; a chain of N nodes ending in the End marker SHALL assert Done N+1 cycles after Start is sampled.
REQ-025 DONE: lasts one cycle with Done=1, Busy=0, Valid=0; then IDLE; Steps and Reason hold.
REQ-026 Write and Start during WALK or DONE SHALL be ignored; memory contents are unchanged by a walk.
REQ-027 Address wrap: when WordsNumber is not a power of two, data values from WordsNumber to 2^AddrWidth-1 SHALL report RangeError, never an out-of-range read.

Reset
REQ-028 Reset low SHALL force IDLE, Busy=0, Valid=0, Done=0, Address=0, Steps=0, Reason=0, even mid-walk.
REQ-029 Memory contents SHALL NOT be reset; a write coinciding with reset assertion is lost.

Structure
REQ-030 Package list_walker_pkg SHALL hold the state enum, the Reason codes and the clog2 function.
REQ-031 Storage SHALL be one sub-module list_walker_mem (sync write, async read, WordSize x WordsNumber); the FSM, counter and compare logic stay in list_walker.

Verification
REQ-032 Load 4,1,3,4,2,5,6,0 into addresses 0..7, Start at 0 -> Address sequence 0,4,2,3,4,2,3,4; Done with Reason=Loop, Steps=8.
REQ-033 Load 0:2, 2:5, 5:all-ones, Start at 0 -> Address 0,2,5; Done with Reason=End, Steps=3, exactly 4 cycles after Start is sampled.
REQ-034 Load 0:1, 1:9 (WordsNumber=8), Start at 0 -> visits 0,1; Reason=RangeError, Steps=2.
REQ-035 Assert Reset low during the third WALK cycle -> all outputs return to reset values asynchronously; a new Start walks correctly.
REQ-036 Pulse Start and Write during WALK -> no effect on the walk or memory; a later read confirms the original contents.
REQ-037 Repeat REQ-032 with WordSize=16, WordsNumber=6, data 3,0,all-ones, 7, … -> RangeError on value 7 (non-power-of-two depth).

Source files
------------

// File: rtl/list_walker_pkg.sv
// Shared definitions for the linked-list walker: FSM states, end-cause codes
// and the ceiling-log2 helper used to size address and step counters.
package list_walker_pkg;

  localparam int unsigned ReasonWidth = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WALK = 2'd1,
    S_DONE = 2'd2
  } state_e;

  typedef enum logic [ReasonWidth-1:0] {
    REASON_END   = 2'd0,
    REASON_RANGE = 2'd1,
    REASON_LOOP  = 2'd2
  } reason_e;

  // Smallest r with 2**r >= n (n >= 1).
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r++;
    return r;
  endfunction

endpackage

// File: rtl/list_walker_mem.sv
// Node storage: WordSize x WordsNumber, synchronous write, asynchronous read.
// Ports: clk_i; we_i/waddr_i/wdata_i write port; raddr_i -> rdata_o read port.
// Addresses beyond the depth (non-power-of-two depths only) never touch the
// array: writes are dropped and reads return all-ones.
module list_walker_mem
  import list_walker_pkg::*;
#(
  parameter int unsigned WordSize    = 32,
  parameter int unsigned WordsNumber = 8,
  localparam int unsigned AddrWidth  = clog2(WordsNumber)
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] waddr_i,
  input  logic [WordSize-1:0]  wdata_i,
  input  logic [AddrWidth-1:0] raddr_i,
  output logic [WordSize-1:0]  rdata_o
);

  localparam bit FullDepth = (WordsNumber == (32'd1 << AddrWidth));

  logic [WordSize-1:0] mem_q [WordsNumber];
  logic                w_ok;
  logic                r_ok;

  // Range guards only exist when the address space has unused codes.
  if (FullDepth) begin : g_full
    assign w_ok = 1'b1;
    assign r_ok = 1'b1;
  end else begin : g_part
    assign w_ok = (32'(waddr_i) < WordsNumber);
    assign r_ok = (32'(raddr_i) < WordsNumber);
  end

  // Contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (we_i && w_ok) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = r_ok ? mem_q[raddr_i] : '1;

endmodule

// File: rtl/list_walker.sv
// Walks a linked list stored in an internal memory: each word holds the
// address of the next node; all-ones marks the end of the list.
// Ports: clk_i, rst_ni (async, active-low); write_i/write_address_i/
// write_data_i load the memory while idle; start_i/start_address_i launch a
// walk; busy_o/valid_o/address_o/data_o show the visited node; steps_o counts
// visited nodes; done_o pulses at walk end with reason_o holding the cause.
module list_walker
  import list_walker_pkg::*;
#(
  parameter int unsigned WordSize    = 32,
  parameter int unsigned WordsNumber = 8,
  localparam int unsigned AddrWidth  = clog2(WordsNumber),
  localparam int unsigned CountWidth = clog2(WordsNumber + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   write_i,
  input  logic [AddrWidth-1:0]   write_address_i,
  input  logic [WordSize-1:0]    write_data_i,
  input  logic                   start_i,
  input  logic [AddrWidth-1:0]   start_address_i,
  output logic                   busy_o,
  output logic                   valid_o,
  output logic [AddrWidth-1:0]   address_o,
  output logic [WordSize-1:0]    data_o,
  output logic [CountWidth-1:0]  steps_o,
  output logic                   done_o,
  output logic [ReasonWidth-1:0] reason_o
);

  localparam logic [WordSize-1:0]   DepthW = WordSize'(WordsNumber);
  localparam logic [CountWidth-1:0] DepthC = CountWidth'(WordsNumber);

  state_e                state_q, state_d;
  logic [AddrWidth-1:0]  address_q, address_d;
  logic [CountWidth-1:0] steps_q, steps_d;
  reason_e               reason_q, reason_d;
  logic                  busy_q, busy_d;
  logic                  valid_q, valid_d;
  logic                  done_q, done_d;

  logic [WordSize-1:0]   rd_data;
  logic [CountWidth-1:0] steps_inc;
  logic                  mem_we;

  // Loading is only allowed while idle; a write during reset is dropped.
  assign mem_we = rst_ni && write_i && (state_q == S_IDLE);

  list_walker_mem #(
    .WordSize   (WordSize),
    .WordsNumber(WordsNumber)
  ) u_mem (
    .clk_i  (clk_i),
    .we_i   (mem_we),
    .waddr_i(write_address_i),
    .wdata_i(write_data_i),
    .raddr_i(address_q),
    .rdata_o(rd_data)
  );

  assign steps_inc = steps_q + CountWidth'(1);

  // State, datapath and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      address_q <= '0;
      steps_q   <= '0;
      reason_q  <= REASON_END;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      address_q <= address_d;
      steps_q   <= steps_d;
      reason_q  <= reason_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
    end
  end

  // Next state: follow the pointer each WALK cycle, stop on the first
  // termination condition in priority order End > RangeError > Loop.
  always_comb begin
    state_d   = state_q;
    address_d = address_q;
    steps_d   = steps_q;
    reason_d  = reason_q;
    case (state_q)
      S_IDLE: begin
        if (start_i && !write_i) begin
          state_d   = S_WALK;
          address_d = start_address_i;
          steps_d   = '0;
          reason_d  = REASON_END;
        end
      end
      S_WALK: begin
        steps_d = steps_inc;
        if (&rd_data) begin
          state_d  = S_DONE;
          reason_d = REASON_END;
        end else if (rd_data >= DepthW) begin
          state_d  = S_DONE;
          reason_d = REASON_RANGE;
        end else if (steps_inc == DepthC) begin
          state_d  = S_DONE;
          reason_d = REASON_LOOP;
        end else begin
          address_d = rd_data[AddrWidth-1:0];
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the upcoming state so the flags are registered.
  always_comb begin
    busy_d  = 1'b0;
    valid_d = 1'b0;
    done_d  = 1'b0;
    case (state_d)
      S_WALK: begin
        busy_d  = 1'b1;
        valid_d = 1'b1;
      end
      S_DONE:  done_d = 1'b1;
      default: ;
    endcase
  end

  assign busy_o    = busy_q;
  assign valid_o   = valid_q;
  assign done_o    = done_q;
  assign address_o = address_q;
  assign data_o    = rd_data;
  assign steps_o   = steps_q;
  assign reason_o  = reason_q;

endmodule

// File: tb/tb_list_walker.sv
// Bench for list_walker: instance A (32 x 8) checked every cycle against a
// list-following model; instance B (16 x 6) checked with literal vectors.
module tb_list_walker;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance A: defaults.
  logic        write_a, start_a;
  logic [2:0]  waddr_a, start_addr_a;
  logic [31:0] wdata_a;
  logic        busy_a, valid_a, done_a;
  logic [2:0]  address_a;
  logic [31:0] data_a;
  logic [3:0]  steps_a;
  logic [1:0]  reason_a;

  // Instance B: 16-bit words, depth 6.
  logic        write_b, start_b;
  logic [2:0]  waddr_b, start_addr_b;
  logic [15:0] wdata_b;
  logic        busy_b, valid_b, done_b;
  logic [2:0]  address_b;
  logic [15:0] data_b;
  logic [2:0]  steps_b;
  logic [1:0]  reason_b;

  list_walker dut_a (
    .clk_i(clk), .rst_ni(rst_n),
    .write_i(write_a), .write_address_i(waddr_a), .write_data_i(wdata_a),
    .start_i(start_a), .start_address_i(start_addr_a),
    .busy_o(busy_a), .valid_o(valid_a), .address_o(address_a), .data_o(data_a),
    .steps_o(steps_a), .done_o(done_a), .reason_o(reason_a)
  );

  list_walker #(.WordSize(16), .WordsNumber(6)) dut_b (
    .clk_i(clk), .rst_ni(rst_n),
    .write_i(write_b), .write_address_i(waddr_b), .write_data_i(wdata_b),
    .start_i(start_b), .start_address_i(start_addr_b),
    .busy_o(busy_b), .valid_o(valid_b), .address_o(address_b), .data_o(data_b),
    .steps_o(steps_b), .done_o(done_b), .reason_o(reason_b)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Model state for instance A.
  logic [31:0] mem_a [8];
  bit cmp_en = 1'b0;
  int exp_busy = 0, exp_valid = 0, exp_done = 0;
  int exp_addr = 0, exp_steps = 0, exp_reason = 0;
  int obs_q[$];
  int cyc = 0, start_cyc = 0, done_at = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Per-cycle comparison of instance A against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("a_busy", busy_a, exp_busy);
      chk("a_valid", valid_a, exp_valid);
      chk("a_done", done_a, exp_done);
      chk("a_addr", address_a, exp_addr);
      chk("a_data", data_a, mem_a[exp_addr]);
      chk("a_steps", steps_a, exp_steps);
      if (exp_busy == 0) chk("a_reason", reason_a, exp_reason);
      if (valid_a) obs_q.push_back(int'(address_a));
      if (done_a) done_at <= cyc;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_a(input int ad, input logic [31:0] dv);
    write_a = 1'b1; waddr_a = 3'(ad); wdata_a = dv;
    step();
    write_a = 1'b0;
    mem_a[ad] = dv;
  endtask

  task automatic wr_b(input int ad, input logic [15:0] dv);
    write_b = 1'b1; waddr_b = 3'(ad); wdata_b = dv;
    step();
    write_b = 1'b0;
  endtask

  // Follow the model list to get the node trace, then drive the walk and
  // publish the expected outputs cycle by cycle.
  task automatic walk_a(input int sa, input bit disturb);
    int tr[$];
    int a, n, r;
    logic [31:0] d;
    a = sa; n = 0; r = 0;
    while (1'b1) begin
      tr.push_back(a);
      d = mem_a[a];
      n++;
      if (d == 32'hFFFF_FFFF) begin r = 0; break; end
      if (d >= 32'd8) begin r = 1; break; end
      if (n == 8) begin r = 2; break; end
      a = int'(d);
    end
    obs_q.delete();
    start_cyc = cyc;
    start_a = 1'b1; start_addr_a = 3'(sa);
    step();
    start_a = 1'b0;
    for (int k = 0; k < n; k++) begin
      exp_busy = 1; exp_valid = 1; exp_done = 0;
      exp_addr = tr[k]; exp_steps = k;
      if (disturb && k == 1) begin
        write_a = 1'b1; waddr_a = 3'(tr[0]); wdata_a = 32'h0;
        start_a = 1'b1; start_addr_a = 3'd7;
      end else begin
        write_a = 1'b0; start_a = 1'b0;
      end
      step();
    end
    write_a = 1'b0; start_a = 1'b0;
    exp_busy = 0; exp_valid = 0; exp_done = 1;
    exp_steps = n; exp_reason = r;
    step();
    exp_done = 0;
    step();
  endtask

  task automatic chk_obs(input string nm, input int n,
                         input int e0, input int e1, input int e2, input int e3,
                         input int e4, input int e5, input int e6, input int e7);
    int e[8];
    e = '{e0, e1, e2, e3, e4, e5, e6, e7};
    chk({nm, "_len"}, obs_q.size(), n);
    for (int k = 0; k < n; k++)
      if (k < obs_q.size()) chk(nm, obs_q[k], e[k]);
  endtask

  task automatic walk_b(input int sa, input int n, input int a0, input int a1,
                        input int a2, input int a3, input int a4, input int a5,
                        input int r);
    int ea[6];
    ea = '{a0, a1, a2, a3, a4, a5};
    start_b = 1'b1; start_addr_b = 3'(sa);
    step();
    start_b = 1'b0;
    for (int k = 0; k < n; k++) begin
      chk("b_busy", busy_b, 1);
      chk("b_valid", valid_b, 1);
      chk("b_addr", address_b, ea[k]);
      step();
    end
    chk("b_done", done_b, 1);
    chk("b_busy_done", busy_b, 0);
    chk("b_reason", reason_b, r);
    chk("b_steps", steps_b, n);
    step();
    chk("b_done_clr", done_b, 0);
  endtask

  task automatic chk_reset_values();
    chk("rst_a_busy", busy_a, 0);
    chk("rst_a_valid", valid_a, 0);
    chk("rst_a_done", done_a, 0);
    chk("rst_a_addr", address_a, 0);
    chk("rst_a_steps", steps_a, 0);
    chk("rst_a_reason", reason_a, 0);
    chk("rst_b_busy", busy_b, 0);
    chk("rst_b_addr", address_b, 0);
    chk("rst_b_steps", steps_b, 0);
  endtask

  initial begin
    rst_n = 1'b1;
    write_a = 1'b0; start_a = 1'b0; waddr_a = '0; wdata_a = '0; start_addr_a = '0;
    write_b = 1'b0; start_b = 1'b0; waddr_b = '0; wdata_b = '0; start_addr_b = '0;
    #3 rst_n = 1'b0;
    #1 chk_reset_values();
    step();
    step();
    rst_n = 1'b1;

    // List with a cycle; the final write also raises Start, which must be ignored.
    wr_a(0, 32'd4); wr_a(1, 32'd1); wr_a(2, 32'd3); wr_a(3, 32'd4);
    wr_a(4, 32'd2); wr_a(5, 32'd5); wr_a(6, 32'd6);
    start_a = 1'b1; start_addr_a = 3'd1;
    wr_a(7, 32'd0);
    start_a = 1'b0;
    exp_busy = 0; exp_valid = 0; exp_done = 0; exp_addr = 0; exp_steps = 0; exp_reason = 0;
    cmp_en = 1'b1;
    step();

    walk_a(0, 1'b0);
    chk_obs("loop_trace", 8, 0, 4, 2, 3, 4, 2, 3, 4);
    chk("loop_steps", steps_a, 8);
    chk("loop_reason", reason_a, 2);

    // Three-node list ending in the marker.
    wr_a(0, 32'd2); wr_a(2, 32'd5); wr_a(5, 32'hFFFF_FFFF);
    walk_a(0, 1'b0);
    chk_obs("end_trace", 3, 0, 2, 5, 0, 0, 0, 0, 0);
    chk("end_steps", steps_a, 3);
    chk("end_reason", reason_a, 0);
    chk("end_latency", done_at - start_cyc, 4);

    // Out-of-range pointer.
    wr_a(0, 32'd1); wr_a(1, 32'd9);
    walk_a(0, 1'b0);
    chk_obs("range_trace", 2, 0, 1, 0, 0, 0, 0, 0, 0);
    chk("range_steps", steps_a, 2);
    chk("range_reason", reason_a, 1);

    // Start/Write pulsed mid-walk must not disturb walk or memory.
    walk_a(3, 1'b1);
    chk_obs("dist_trace", 4, 3, 4, 2, 5, 0, 0, 0, 0);
    walk_a(3, 1'b0);
    chk_obs("dist_reread", 4, 3, 4, 2, 5, 0, 0, 0, 0);
    chk("dist_steps", steps_a, 4);

    // Asynchronous reset in the third walk cycle.
    cmp_en = 1'b0;
    start_a = 1'b1; start_addr_a = 3'd3;
    step();
    start_a = 1'b0;
    step();
    step();
    #2 rst_n = 1'b0;
    #1 chk_reset_values();
    step();
    rst_n = 1'b1;
    exp_busy = 0; exp_valid = 0; exp_done = 0; exp_addr = 0; exp_steps = 0; exp_reason = 0;
    cmp_en = 1'b1;
    step();
    walk_a(3, 1'b0);
    chk_obs("post_rst_trace", 4, 3, 4, 2, 5, 0, 0, 0, 0);

    // Non-power-of-two depth on instance B.
    wr_b(0, 16'd3); wr_b(1, 16'd0); wr_b(2, 16'hFFFF);
    wr_b(3, 16'd7); wr_b(4, 16'd1); wr_b(5, 16'd2);
    step();
    chk("b_idle_data", data_b, 16'd3);
    walk_b(0, 2, 0, 3, 0, 0, 0, 0, 1);
    walk_b(4, 4, 4, 1, 0, 3, 0, 0, 1);
    walk_b(5, 2, 5, 2, 0, 0, 0, 0, 0);
    wr_b(3, 16'd4);
    walk_b(0, 6, 0, 3, 4, 1, 0, 3, 2);
    wr_b(5, 16'd6);
    walk_b(5, 1, 5, 0, 0, 0, 0, 0, 1);

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
